// File: rtl/quad_mem_arbiter_pkg.sv
// quad_mem_arbiter_pkg
// Shared types and constants for the quad-core shared-memory arbiter.
//   arbStateT  : arbiter FSM states (idle, request outstanding, turnaround)
//   coreIdxT   : 2-bit core index, wraps naturally for round-robin math
//   DEFAULT_TIMEOUT : default REQ-state cycle budget before an abort
package quad_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } arbStateT;

   typedef logic [1:0] coreIdxT;

   localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/quad_mem_arbiter_rr_arbiter4.sv
// rr_arbiter4
// Combinational 4-way round-robin picker. The search starts at i_ptr and
// walks upward with 2-bit wrap; the first requesting core wins.
//   i_req   : pending request per core (bit 0 = core 1)
//   i_ptr   : highest-priority core index for this pick
//   o_grant : one-hot grant, all zero when nothing is requested
//   o_idx   : encoded index of the granted core (i_ptr when nothing granted)
module rr_arbiter4
   import quad_mem_arbiter_pkg::*;
(
   input  logic [3:0] i_req,
   input  coreIdxT    i_ptr,
   output logic [3:0] o_grant,
   output coreIdxT    o_idx
);

   coreIdxT w_cand;

   // Walk offsets from farthest to nearest so the candidate closest to
   // i_ptr overwrites any earlier hit and ends up as the winner.
   always_comb begin
      o_grant = '0;
      o_idx   = i_ptr;
      w_cand  = i_ptr;
      for (int i = 3; i >= 0; i--) begin
         w_cand = i_ptr + coreIdxT'(i);
         if (i_req[w_cand]) begin
            o_grant         = '0;
            o_grant[w_cand] = 1'b1;
            o_idx           = w_cand;
         end
      end
   end

endmodule

// File: rtl/quad_mem_arbiter.sv
// quad_mem_arbiter
// Watches four core buses, holds one request slot per core, and serialises
// the slots onto one memory port with round-robin fairness.
//   Clock, nReset            : rising-edge clock, synchronous active-low reset
//   Sysbus*, nME*, nALE*, RnW*: per-core bus and strobes (observed only)
//   Data_in*, Wait*          : per-core registered read data and stall flag
//   BusErr                   : sticky per-core timeout flag (bit 0 = core 1)
//   MemAddr/MemWData/MemWrite/MemReq : memory request port, held during REQ
//   MemRData/MemAck          : memory response
module quad_mem_arbiter
   import quad_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 64,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic              Clock,
   input  logic              nReset,
   input  logic [DATA_W-1:0] Sysbus,
   input  logic [DATA_W-1:0] Sysbus2,
   input  logic [DATA_W-1:0] Sysbus3,
   input  logic [DATA_W-1:0] Sysbus4,
   input  logic              nME,
   input  logic              nME2,
   input  logic              nME3,
   input  logic              nME4,
   input  logic              nALE,
   input  logic              nALE2,
   input  logic              nALE3,
   input  logic              nALE4,
   input  logic              RnW,
   input  logic              RnW2,
   input  logic              RnW3,
   input  logic              RnW4,
   output logic [DATA_W-1:0] Data_in,
   output logic [DATA_W-1:0] Data_in2,
   output logic [DATA_W-1:0] Data_in3,
   output logic [DATA_W-1:0] Data_in4,
   output logic              Wait,
   output logic              Wait2,
   output logic              Wait3,
   output logic              Wait4,
   output logic [3:0]        BusErr,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [DATA_W-1:0] MemWData,
   output logic              MemWrite,
   output logic              MemReq,
   input  logic [DATA_W-1:0] MemRData,
   input  logic              MemAck
);

   logic [DATA_W-1:0] w_sysbus [4];
   logic [3:0]        w_nMe;
   logic [3:0]        w_nAle;
   logic [3:0]        w_rnw;

   logic [ADDR_W-1:0] r_addr   [4];
   logic [DATA_W-1:0] r_wdata  [4];
   logic [DATA_W-1:0] r_dataIn [4];
   logic [3:0]        r_rnw;
   logic [3:0]        r_addrPh;
   logic [3:0]        r_pend;
   logic [3:0]        r_wait;
   logic [3:0]        r_busErr;

   arbStateT          r_state;
   arbStateT          w_nextState;
   coreIdxT           r_ptr;
   coreIdxT           r_winner;
   logic [7:0]        r_count;
   logic [ADDR_W-1:0] r_memAddr;
   logic [DATA_W-1:0] r_memWData;
   logic              r_memWrite;
   logic              r_memReq;

   logic [3:0]        w_grant;
   coreIdxT           w_idx;
   logic              w_timeout;
   logic              w_finish;

   assign w_sysbus[0] = Sysbus;
   assign w_sysbus[1] = Sysbus2;
   assign w_sysbus[2] = Sysbus3;
   assign w_sysbus[3] = Sysbus4;
   assign w_nMe       = {nME4, nME3, nME2, nME};
   assign w_nAle      = {nALE4, nALE3, nALE2, nALE};
   assign w_rnw       = {RnW4, RnW3, RnW2, RnW};

   assign Data_in  = r_dataIn[0];
   assign Data_in2 = r_dataIn[1];
   assign Data_in3 = r_dataIn[2];
   assign Data_in4 = r_dataIn[3];
   assign {Wait4, Wait3, Wait2, Wait} = r_wait;
   assign BusErr   = r_busErr;
   assign MemAddr  = r_memAddr;
   assign MemWData = r_memWData;
   assign MemWrite = r_memWrite;
   assign MemReq   = r_memReq;

   rr_arbiter4 u_rrArb (
      .i_req   (r_pend),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx)
   );

   // An ack always wins over a timeout that would expire on the same edge.
   assign w_timeout = (r_state == ST_REQ) && !MemAck && (r_count == 8'(TIMEOUT - 1));
   assign w_finish  = (r_state == ST_REQ) && (MemAck || w_timeout);

   // Per-core slot: address phase -> data phase -> pending -> served.
   // A slot is busy from address phase until completion, so a new address
   // phase on a busy slot is simply not looked at.
   always_ff @(posedge Clock) begin
      if (!nReset) begin
         for (int k = 0; k < 4; k++) begin
            r_addr[k]   <= '0;
            r_wdata[k]  <= '0;
            r_dataIn[k] <= '0;
         end
         r_rnw    <= '0;
         r_addrPh <= '0;
         r_pend   <= '0;
         r_wait   <= '0;
         r_busErr <= '0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (w_finish && (r_winner == coreIdxT'(k))) begin
               r_pend[k] <= 1'b0;
               r_wait[k] <= 1'b0;
               if (w_timeout) begin
                  r_dataIn[k] <= '1;
                  r_busErr[k] <= 1'b1;
               end else if (r_rnw[k]) begin
                  r_dataIn[k] <= MemRData;
               end
            end else if (!r_addrPh[k] && !r_pend[k]) begin
               if (!w_nMe[k] && !w_nAle[k]) begin
                  r_addr[k]   <= w_sysbus[k][ADDR_W-1:0];
                  r_rnw[k]    <= w_rnw[k];
                  r_addrPh[k] <= 1'b1;
                  r_wait[k]   <= 1'b1;
                  r_busErr[k] <= 1'b0;
               end
            end else if (r_addrPh[k]) begin
               if (w_nMe[k]) begin
                  r_addrPh[k] <= 1'b0;
                  r_wait[k]   <= 1'b0;
               end else if (w_nAle[k]) begin
                  if (!r_rnw[k]) begin
                     r_wdata[k] <= w_sysbus[k];
                  end
                  r_addrPh[k] <= 1'b0;
                  r_pend[k]   <= 1'b1;
               end
            end
         end
      end
   end

   // FSM state register plus the memory-port registers it owns. The port
   // is loaded once on grant and left alone for the whole REQ phase.
   always_ff @(posedge Clock) begin
      if (!nReset) begin
         r_state    <= ST_IDLE;
         r_ptr      <= '0;
         r_winner   <= '0;
         r_count    <= '0;
         r_memAddr  <= '0;
         r_memWData <= '0;
         r_memWrite <= 1'b0;
         r_memReq   <= 1'b0;
      end else begin
         r_state <= w_nextState;
         case (r_state)
            ST_IDLE: begin
               if (|w_grant) begin
                  r_winner   <= w_idx;
                  r_memAddr  <= r_addr[w_idx];
                  r_memWData <= r_wdata[w_idx];
                  r_memWrite <= !r_rnw[w_idx];
                  r_memReq   <= 1'b1;
                  r_count    <= '0;
               end
            end
            ST_REQ: begin
               if (w_finish) begin
                  r_memReq <= 1'b0;
               end else begin
                  r_count <= r_count + 8'd1;
               end
            end
            ST_DONE: begin
               r_ptr <= r_winner + coreIdxT'(1);
            end
            default: ;
         endcase
      end
   end

   // Next-state logic; the DONE cycle is an unconditional turnaround.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_IDLE: if (|w_grant) w_nextState = ST_REQ;
         ST_REQ:  if (w_finish) w_nextState = ST_DONE;
         ST_DONE: w_nextState = ST_IDLE;
         default: w_nextState = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_quad_mem_arbiter.sv
// tb_quad_mem_arbiter
// Directed bench for quad_mem_arbiter: single read/write, four-way
// contention with a second round, timeout abort, reset mid-request and an
// aborted capture. Inputs change on the falling edge; outputs are sampled
// on the falling edge too.
module tb_quad_mem_arbiter;

   logic        Clock = 1'b0;
   logic        nReset;
   logic [63:0] bus   [4];
   logic        nme   [4];
   logic        nale  [4];
   logic        rnw   [4];
   logic [63:0] dataIn [4];
   logic        waitV [4];
   logic [3:0]  BusErr;
   logic [15:0] MemAddr;
   logic [63:0] MemWData;
   logic        MemWrite;
   logic        MemReq;
   logic [63:0] MemRData;
   logic        MemAck;

   logic [15:0] reqAddr [4];
   int          total = 0;
   int          bad   = 0;

   always #5 Clock = ~Clock;

   quad_mem_arbiter dut (
      .Clock    (Clock),
      .nReset   (nReset),
      .Sysbus   (bus[0]),
      .Sysbus2  (bus[1]),
      .Sysbus3  (bus[2]),
      .Sysbus4  (bus[3]),
      .nME      (nme[0]),
      .nME2     (nme[1]),
      .nME3     (nme[2]),
      .nME4     (nme[3]),
      .nALE     (nale[0]),
      .nALE2    (nale[1]),
      .nALE3    (nale[2]),
      .nALE4    (nale[3]),
      .RnW      (rnw[0]),
      .RnW2     (rnw[1]),
      .RnW3     (rnw[2]),
      .RnW4     (rnw[3]),
      .Data_in  (dataIn[0]),
      .Data_in2 (dataIn[1]),
      .Data_in3 (dataIn[2]),
      .Data_in4 (dataIn[3]),
      .Wait     (waitV[0]),
      .Wait2    (waitV[1]),
      .Wait3    (waitV[2]),
      .Wait4    (waitV[3]),
      .BusErr   (BusErr),
      .MemAddr  (MemAddr),
      .MemWData (MemWData),
      .MemWrite (MemWrite),
      .MemReq   (MemReq),
      .MemRData (MemRData),
      .MemAck   (MemAck)
   );

   // Single comparison point: counts every check, reports any difference.
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge Clock);
   endtask

   // Address phase then data phase for every core in mask; returns on the
   // falling edge after the data-phase edge, when the slots are pending.
   task automatic applyStimulus(input logic [3:0] mask, input logic isRead, input logic [63:0] wdata);
      for (int k = 0; k < 4; k++) begin
         if (mask[k]) begin
            nme[k]  = 1'b0;
            nale[k] = 1'b0;
            rnw[k]  = isRead;
            bus[k]  = {48'hFFFF_0000_FFFF, reqAddr[k]};
         end
      end
      tick();
      for (int k = 0; k < 4; k++) begin
         if (mask[k]) begin
            nale[k] = 1'b1;
            bus[k]  = wdata;
         end
      end
      tick();
      for (int k = 0; k < 4; k++) begin
         if (mask[k]) begin
            nme[k] = 1'b1;
            bus[k] = '0;
         end
      end
   endtask

   // Expects a read grant for core on the next edge, acks it one cycle
   // later and then lets the DONE turnaround pass.
   task automatic serveRead(input int core, input logic [15:0] expAddr, input logic [63:0] rdata);
      tick();
      checkOutput($sformatf("memReq c%0d", core + 1), {63'b0, MemReq}, 64'd1);
      checkOutput($sformatf("memAddr c%0d", core + 1), {48'b0, MemAddr}, {48'b0, expAddr});
      checkOutput($sformatf("memWrite c%0d", core + 1), {63'b0, MemWrite}, 64'd0);
      checkOutput($sformatf("waitHi c%0d", core + 1), {63'b0, waitV[core]}, 64'd1);
      MemAck   = 1'b1;
      MemRData = rdata;
      tick();
      MemAck   = 1'b0;
      MemRData = '0;
      checkOutput($sformatf("dataIn c%0d", core + 1), dataIn[core], rdata);
      checkOutput($sformatf("waitLo c%0d", core + 1), {63'b0, waitV[core]}, 64'd0);
      checkOutput($sformatf("memReqLo c%0d", core + 1), {63'b0, MemReq}, 64'd0);
      tick();
   endtask

   initial begin
      nReset   = 1'b0;
      MemAck   = 1'b0;
      MemRData = '0;
      for (int k = 0; k < 4; k++) begin
         bus[k] = '0; nme[k] = 1'b1; nale[k] = 1'b1; rnw[k] = 1'b1; reqAddr[k] = '0;
      end
      repeat (3) tick();

      // Reset state
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("rstData c%0d", k + 1), dataIn[k], 64'd0);
         checkOutput($sformatf("rstWait c%0d", k + 1), {63'b0, waitV[k]}, 64'd0);
      end
      checkOutput("rstBusErr", {60'b0, BusErr}, 64'd0);
      checkOutput("rstMemReq", {63'b0, MemReq}, 64'd0);
      checkOutput("rstMemAddr", {48'b0, MemAddr}, 64'd0);
      checkOutput("rstMemWrite", {63'b0, MemWrite}, 64'd0);
      nReset = 1'b1;
      tick();

      // Single read from core 1
      reqAddr[0] = 16'h0010;
      applyStimulus(4'b0001, 1'b1, 64'd0);
      checkOutput("rd noReqYet", {63'b0, MemReq}, 64'd0);
      serveRead(0, 16'h0010, 64'hDEADBEEF_00000001);

      // Single write from core 3
      reqAddr[2] = 16'h0100;
      applyStimulus(4'b0100, 1'b0, 64'h5A5A5A5A_5A5A5A5A);
      tick();
      checkOutput("wr memReq", {63'b0, MemReq}, 64'd1);
      checkOutput("wr memWrite", {63'b0, MemWrite}, 64'd1);
      checkOutput("wr memAddr", {48'b0, MemAddr}, 64'h0100);
      checkOutput("wr memWData", MemWData, 64'h5A5A5A5A_5A5A5A5A);
      MemAck   = 1'b1;
      MemRData = 64'h11111111_11111111;
      tick();
      MemAck   = 1'b0;
      MemRData = '0;
      checkOutput("wr dataInUnchanged", dataIn[2], 64'd0);
      checkOutput("wr waitLo", {63'b0, waitV[2]}, 64'd0);
      tick();

      // Core 4 read brings the pointer back round to core 1
      reqAddr[3] = 16'h0040;
      applyStimulus(4'b1000, 1'b1, 64'd0);
      serveRead(3, 16'h0040, 64'h44444444_00000040);

      // Four-way contention with ptr at core 1
      reqAddr[0] = 16'h1000; reqAddr[1] = 16'h2000;
      reqAddr[2] = 16'h3000; reqAddr[3] = 16'h4000;
      applyStimulus(4'b1111, 1'b1, 64'd0);
      serveRead(0, 16'h1000, 64'hA0000000_00001000);
      checkOutput("cont wait4Held", {63'b0, waitV[3]}, 64'd1);
      serveRead(1, 16'h2000, 64'hA0000000_00002000);
      // Second round: cores 1 and 2 re-request, ptr now at core 3
      reqAddr[0] = 16'h1100; reqAddr[1] = 16'h2200;
      applyStimulus(4'b0011, 1'b1, 64'd0);
      serveRead(2, 16'h3000, 64'hA0000000_00003000);
      serveRead(3, 16'h4000, 64'hA0000000_00004000);
      serveRead(0, 16'h1100, 64'hB0000000_00001100);
      serveRead(1, 16'h2200, 64'hB0000000_00002200);

      // Timeout on core 2: 16 REQ cycles without an ack
      reqAddr[1] = 16'h0200;
      applyStimulus(4'b0010, 1'b1, 64'd0);
      tick();
      checkOutput("to memAddr", {48'b0, MemAddr}, 64'h0200);
      repeat (15) tick();
      checkOutput("to stillReq", {63'b0, MemReq}, 64'd1);
      tick();
      checkOutput("to memReqLo", {63'b0, MemReq}, 64'd0);
      checkOutput("to dataOnes", dataIn[1], 64'hFFFFFFFF_FFFFFFFF);
      checkOutput("to busErr", {60'b0, BusErr}, 64'h2);
      checkOutput("to waitLo", {63'b0, waitV[1]}, 64'd0);
      tick();
      reqAddr[1] = 16'h0210;
      applyStimulus(4'b0010, 1'b1, 64'd0);
      checkOutput("to busErrCleared", {60'b0, BusErr}, 64'h0);
      serveRead(1, 16'h0210, 64'h22222222_00000210);

      // Reset in the middle of REQ, then a late ack
      reqAddr[0] = 16'h0300;
      applyStimulus(4'b0001, 1'b1, 64'd0);
      tick();
      checkOutput("mr inReq", {63'b0, MemReq}, 64'd1);
      nReset = 1'b0;
      tick();
      nReset = 1'b1;
      checkOutput("mr memReq", {63'b0, MemReq}, 64'd0);
      checkOutput("mr memAddr", {48'b0, MemAddr}, 64'd0);
      checkOutput("mr wait1", {63'b0, waitV[0]}, 64'd0);
      checkOutput("mr data2", dataIn[1], 64'd0);
      MemAck   = 1'b1;
      MemRData = 64'hBADBADBA_DBADBADB;
      repeat (2) tick();
      MemAck   = 1'b0;
      MemRData = '0;
      checkOutput("mr lateAckReq", {63'b0, MemReq}, 64'd0);
      checkOutput("mr lateAckData", dataIn[0], 64'd0);

      // Aborted capture on core 4
      nme[3] = 1'b0; nale[3] = 1'b0; rnw[3] = 1'b1; bus[3] = 64'h0000_0000_0000_0500;
      tick();
      checkOutput("ab waitSet", {63'b0, waitV[3]}, 64'd1);
      nme[3] = 1'b1; nale[3] = 1'b1; bus[3] = '0;
      tick();
      checkOutput("ab waitCleared", {63'b0, waitV[3]}, 64'd0);
      repeat (3) tick();
      checkOutput("ab noMemReq", {63'b0, MemReq}, 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
